// File: rtl/vector_list_writer_pkg.sv
// Shared definitions for the vector list writer: command codes, FSM states,
// point limit and the byte offsets of a line record.
// Record layout: [len][attr][x0][y0]..[xN][yN], list closed by a 0 byte.
package vector_list_writer_pkg;

    typedef enum logic [1:0] {
        CMD_BEGIN_LINE = 2'd0,
        CMD_POINT      = 2'd1,
        CMD_END_LINE   = 2'd2,
        CMD_END_LIST   = 2'd3
    } cmd_type_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BEGIN_W0,
        ST_BEGIN_W1,
        ST_PT_X,
        ST_PT_Y,
        ST_PAD_X,
        ST_PAD_Y,
        ST_END_TERM,
        ST_END_LEN,
        ST_LIST_TERM,
        ST_DONE
    } state_t;

    // Point counter is wide enough to hold MAX_POINTS.
    localparam int COUNT_W = 9;
    localparam logic [COUNT_W-1:0] MAX_POINTS = 9'd257;

    // Byte offsets inside a line record, relative to line_start.
    localparam int REC_LEN_OFS  = 0;
    localparam int REC_ATTR_OFS = 1;
    localparam int REC_PT_OFS   = 2;

    // Length byte stored in a record: number of points minus two.
    function automatic logic [7:0] len_byte(input logic [COUNT_W-1:0] n);
        logic [COUNT_W-1:0] l;
        l = n - COUNT_W'(2);
        return l[7:0];
    endfunction

endpackage

// File: rtl/vector_list_writer.sv
// Vector list writer: turns BEGIN_LINE / POINT / END_LINE / END_LIST commands
// into byte writes that build a renderer display list in a vector RAM.
// Ports: clk/reset (async, active-high); cmd_valid/cmd_ready handshake with
// cmd_type, cmd_x, cmd_y; ram_addr/ram_data/ram_write byte write port;
// overflow (sticky, cleared by END_LIST); done (one-cycle pulse after the
// list terminator has been written).
// Every FSM state other than IDLE and DONE performs exactly one byte write,
// and that write is presented on the registered RAM port while in the state.
module vector_list_writer
    import vector_list_writer_pkg::*;
#(
    parameter int VECTOR_RAM_WIDTH = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_type,
    input  logic [7:0]                  cmd_x,
    input  logic [7:0]                  cmd_y,
    output logic [VECTOR_RAM_WIDTH-1:0] ram_addr,
    output logic [7:0]                  ram_data,
    output logic                        ram_write,
    output logic                        overflow,
    output logic                        done
);

    localparam int W = VECTOR_RAM_WIDTH;
    // Highest pointer from which two more bytes still fit: 2^W-3.
    localparam logic [W-1:0] PTR_LIMIT = {{(W-2){1'b1}}, 2'b01};

    state_t               state;
    logic [W-1:0]         wr_ptr;
    logic [W-1:0]         line_start;
    logic [COUNT_W-1:0]   count;
    logic                 line_open;
    logic                 discard;     // current close is discarding the line
    cmd_type_t            pend;        // command that started the current sequence
    logic [7:0]           cmd_x_q;
    logic [7:0]           cmd_y_q;
    logic [7:0]           last_x;
    logic [7:0]           last_y;

    cmd_type_t            cmd;
    logic                 pt_ok;
    logic [W-1:0]         post_ptr;
    state_t               close_state;
    logic [W-1:0]         close_addr;
    logic [7:0]           close_data;
    logic                 close_discard;
    logic                 close_ovf;

    assign cmd       = cmd_type_t'(cmd_type);
    assign cmd_ready = (state == ST_IDLE);

    assign pt_ok = line_open && (wr_ptr <= PTR_LIMIT) && (count != MAX_POINTS);

    // Where the pointer lands once a close finishes: a discarded line gives
    // its space back, a kept line leaves the pointer on its terminator so the
    // next record overwrites it.
    assign post_ptr = discard ? line_start : wr_ptr;

    // First step of closing the open line (or of discarding when no line is
    // open). Default is the discard path: a single 0 write at line_start.
    always_comb begin
        close_state   = ST_END_LEN;
        close_addr    = line_start;
        close_data    = 8'h00;
        close_discard = 1'b1;
        close_ovf     = line_open;
        if (line_open && count >= COUNT_W'(3)) begin
            close_state   = ST_END_TERM;
            close_addr    = wr_ptr;
            close_discard = 1'b0;
            close_ovf     = 1'b0;
        end else if (line_open && count == COUNT_W'(2) && wr_ptr <= PTR_LIMIT) begin
            // Two-point line: repeat the last point so the record holds three.
            close_state   = ST_PAD_X;
            close_addr    = wr_ptr;
            close_data    = last_x;
            close_discard = 1'b0;
            close_ovf     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            line_start <= '0;
            count      <= '0;
            line_open  <= 1'b0;
            discard    <= 1'b0;
            pend       <= CMD_BEGIN_LINE;
            cmd_x_q    <= 8'h00;
            cmd_y_q    <= 8'h00;
            last_x     <= 8'h00;
            last_y     <= 8'h00;
            ram_write  <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= 8'h00;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            ram_write <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        pend    <= cmd;
                        cmd_x_q <= cmd_x;
                        cmd_y_q <= cmd_y;
                        if (cmd == CMD_POINT) begin
                            if (pt_ok) begin
                                state     <= ST_PT_X;
                                ram_write <= 1'b1;
                                ram_addr  <= wr_ptr;
                                ram_data  <= cmd_x;
                                last_x    <= cmd_x;
                                last_y    <= cmd_y;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (cmd == CMD_END_LINE || line_open) begin
                            // BEGIN and END_LIST close an open line first;
                            // END_LINE always goes through the close path.
                            state     <= close_state;
                            ram_write <= 1'b1;
                            ram_addr  <= close_addr;
                            ram_data  <= close_data;
                            discard   <= close_discard;
                            if (close_ovf) begin
                                overflow <= 1'b1;
                            end
                        end else if (cmd == CMD_END_LIST) begin
                            state     <= ST_LIST_TERM;
                            ram_write <= 1'b1;
                            ram_addr  <= wr_ptr;
                            ram_data  <= 8'h00;
                        end else if (wr_ptr > PTR_LIMIT) begin
                            overflow <= 1'b1;
                        end else begin
                            state      <= ST_BEGIN_W0;
                            line_start <= wr_ptr;
                            ram_write  <= 1'b1;
                            ram_addr   <= wr_ptr;
                            ram_data   <= 8'h00;
                        end
                    end
                end
                ST_BEGIN_W0: begin
                    state     <= ST_BEGIN_W1;
                    ram_write <= 1'b1;
                    ram_addr  <= line_start + W'(REC_ATTR_OFS);
                    ram_data  <= cmd_x_q;
                end
                ST_BEGIN_W1: begin
                    state     <= ST_IDLE;
                    wr_ptr    <= line_start + W'(REC_PT_OFS);
                    count     <= '0;
                    line_open <= 1'b1;
                end
                ST_PT_X: begin
                    state     <= ST_PT_Y;
                    ram_write <= 1'b1;
                    ram_addr  <= wr_ptr + W'(1);
                    ram_data  <= cmd_y_q;
                    wr_ptr    <= wr_ptr + W'(2);
                    count     <= count + COUNT_W'(1);
                end
                ST_PT_Y: begin
                    state <= ST_IDLE;
                end
                ST_PAD_X: begin
                    state     <= ST_PAD_Y;
                    ram_write <= 1'b1;
                    ram_addr  <= wr_ptr + W'(1);
                    ram_data  <= last_y;
                    wr_ptr    <= wr_ptr + W'(2);
                    count     <= count + COUNT_W'(1);
                end
                ST_PAD_Y: begin
                    state     <= ST_END_TERM;
                    ram_write <= 1'b1;
                    ram_addr  <= wr_ptr;
                    ram_data  <= 8'h00;
                end
                ST_END_TERM: begin
                    // Length goes in only after the terminator is in place,
                    // so the renderer never follows a length into garbage.
                    state     <= ST_END_LEN;
                    ram_write <= 1'b1;
                    ram_addr  <= line_start + W'(REC_LEN_OFS);
                    ram_data  <= len_byte(count);
                end
                ST_END_LEN: begin
                    line_open  <= 1'b0;
                    discard    <= 1'b0;
                    wr_ptr     <= post_ptr;
                    line_start <= post_ptr;
                    state      <= ST_IDLE;
                    if (pend == CMD_END_LIST) begin
                        state     <= ST_LIST_TERM;
                        ram_write <= 1'b1;
                        ram_addr  <= post_ptr;
                        ram_data  <= 8'h00;
                    end else if (pend == CMD_BEGIN_LINE) begin
                        if (post_ptr > PTR_LIMIT) begin
                            overflow <= 1'b1;
                        end else begin
                            state     <= ST_BEGIN_W0;
                            ram_write <= 1'b1;
                            ram_addr  <= post_ptr;
                            ram_data  <= 8'h00;
                        end
                    end
                end
                ST_LIST_TERM: begin
                    state      <= ST_DONE;
                    done       <= 1'b1;
                    wr_ptr     <= '0;
                    line_start <= '0;
                    count      <= '0;
                    overflow   <= 1'b0;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_list_writer.sv
// Bench for vector_list_writer: directed list scenarios plus random commands.
// A 1 KiB RAM lets a single line reach the 257-point limit while the
// end-of-RAM capacity edge (pointer 2^W-2) is still reachable.
module tb_vector_list_writer;
    import vector_list_writer_pkg::*;

    localparam int W   = 10;
    localparam int LIM = (1 << W) - 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_type = 2'd0;
    logic [7:0]   cmd_x = 8'h00;
    logic [7:0]   cmd_y = 8'h00;
    logic [W-1:0] ram_addr;
    logic [7:0]   ram_data;
    logic         ram_write;
    logic         overflow;
    logic         done;

    vector_list_writer #(.VECTOR_RAM_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_write (ram_write),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  wlog[$];      // every observed write, encoded addr<<8 | data
    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_seen = 0;

    // Reference model: the list as the renderer sees it.
    int m_ptr, m_ls, m_n, m_lx, m_ly;
    int m_done = 0;
    bit m_open, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d & 255;
        exp_q.push_back(e);
    endfunction

    function automatic void m_reset();
        m_ptr = 0; m_ls = 0; m_n = 0; m_lx = 0; m_ly = 0;
        m_open = 1'b0; m_ovf = 1'b0;
    endfunction

    // Close whatever is at line_start: keep lines of 3+ points, pad a
    // 2-point line when room allows, otherwise erase it.
    function automatic void m_close();
        if (m_open && m_n >= 3) begin
            push(m_ptr, 0);
            push(m_ls, m_n - 2);
            m_ls = m_ptr;
        end else if (m_open && m_n == 2 && m_ptr <= LIM) begin
            push(m_ptr, m_lx);
            push(m_ptr + 1, m_ly);
            m_ptr = m_ptr + 2;
            push(m_ptr, 0);
            push(m_ls, 1);
            m_ls = m_ptr;
        end else begin
            push(m_ls, 0);
            m_ptr = m_ls;
            if (m_open) m_ovf = 1'b1;
        end
        m_open = 1'b0;
    endfunction

    function automatic void m_cmd(input int t, input int x, input int y);
        case (t)
            0: begin
                if (m_open) m_close();
                if (m_ptr > LIM) m_ovf = 1'b1;
                else begin
                    m_ls = m_ptr;
                    push(m_ls, 0);
                    push(m_ls + 1, x);
                    m_ptr = m_ls + 2;
                    m_n = 0;
                    m_open = 1'b1;
                end
            end
            1: begin
                if (!m_open || m_ptr > LIM || m_n == 257) m_ovf = 1'b1;
                else begin
                    push(m_ptr, x);
                    push(m_ptr + 1, y);
                    m_ptr = m_ptr + 2;
                    m_n++;
                    m_lx = x;
                    m_ly = y;
                end
            end
            2: m_close();
            default: begin
                if (m_open) m_close();
                push(m_ptr, 0);
                m_ptr = 0;
                m_ls = 0;
                m_ovf = 1'b0;
                m_done++;
            end
        endcase
    endfunction

    // Monitor: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_write) begin
                wlog.push_back((int'(ram_addr) << 8) | int'(ram_data));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", ram_addr, ram_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(ram_addr), e.addr);
                    chk("wr_data", 32'(ram_data), e.data);
                end
            end
            if (done) done_seen++;
        end
    end

    task automatic send(input int t, input int x, input int y, input bit settle);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b, required 1", cmd_ready);
        end
        m_cmd(t, x, y);
        cmd_type  = 2'(t);
        cmd_x     = 8'(x);
        cmd_y     = 8'(y);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (settle) begin
            guard = 0;
            @(negedge clk);
            while (cmd_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                n_cmp++; n_bad++;
                $display("FAIL idle_timeout: cmd_ready=%b, required 1", cmd_ready);
            end
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("pending_writes", exp_q.size(), 0);
            if (t == 3) chk("done_pulses", done_seen, m_done);
        end
    endtask

    task automatic line(input int attr, input int npts);
        send(0, attr, 0, 1'b1);
        for (int i = 0; i < npts; i++)
            send(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
    endtask

    int req33[11] = '{'h000, 'h13F, 'h20A, 'h314, 'h464, 'h514,
                      'h664, 'h714, 'h800, 'h001, 'h800};

    initial begin
        int sz;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_write", 32'(ram_write), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_data", 32'(ram_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);

        // Two-point line padded to three, then list end.
        wlog.delete();
        send(0, 'h3F, 0, 1'b1);
        send(1, 10, 20, 1'b1);
        send(1, 100, 20, 1'b1);
        send(2, 0, 0, 1'b1);
        send(3, 0, 0, 1'b1);
        chk("req33_count", wlog.size(), 11);
        for (int i = 0; i < 11 && i < wlog.size(); i++)
            chk("req33_write", wlog[i], req33[i]);
        chk("req33_done_once", done_seen, 1);

        // Four points: length 2, terminator at +10 written before length.
        line('h11, 0);
        for (int i = 1; i <= 4; i++) send(1, i, i, 1'b1);
        send(2, 0, 0, 1'b1);
        sz = wlog.size();
        chk("req34_term", wlog[sz-2], 'hA00);
        chk("req34_len", wlog[sz-1], 'h002);
        send(3, 0, 0, 1'b1);

        // One-point line is erased and its space reused.
        send(0, 'h20, 0, 1'b1);
        send(1, 5, 5, 1'b1);
        send(2, 0, 0, 1'b1);
        chk("req35_erase", wlog[wlog.size()-1], 'h000);
        chk("req35_overflow", 32'(overflow), 1);
        send(0, 'h44, 0, 1'b1);
        sz = wlog.size();
        chk("req35_reuse_w0", wlog[sz-2], 'h000);
        chk("req35_reuse_w1", wlog[sz-1], 'h144);
        send(3, 0, 0, 1'b1);
        chk("overflow_cleared", 32'(overflow), 0);

        // Fill to the last byte pair, then overflow at the RAM end.
        line('h01, 200); send(2, 0, 0, 1'b1);
        line('h02, 200); send(2, 0, 0, 1'b1);
        line('h03, 108);
        sz = wlog.size();
        send(1, 1, 2, 1'b1);
        chk("full_point_no_write", wlog.size(), sz);
        chk("full_point_overflow", 32'(overflow), 1);
        send(0, 'h04, 0, 1'b1);
        sz = wlog.size();
        chk("full_close_term", wlog[sz-2], (LIM + 1) << 8);
        send(3, 0, 0, 1'b1);
        chk("full_list_term", wlog[wlog.size()-1], (LIM + 1) << 8);
        chk("full_overflow_cleared", 32'(overflow), 0);

        // Two-point line whose pad no longer fits is discarded.
        line('h05, 255); send(2, 0, 0, 1'b1);
        line('h06, 251); send(2, 0, 0, 1'b1);
        line('h07, 2);
        send(2, 0, 0, 1'b1);
        chk("nofit_erase", wlog[wlog.size()-1], (LIM - 5) << 8);
        line('h08, 2);
        send(3, 0, 0, 1'b1);

        // 258 points: last one dropped, length byte 0xFF.
        line('h09, 258);
        chk("max_pts_overflow", 32'(overflow), 1);
        send(2, 0, 0, 1'b1);
        chk("max_pts_len", wlog[wlog.size()-1], 'h0FF);
        send(3, 0, 0, 1'b1);

        // Reset in the middle of a point write.
        send(0, 'h55, 0, 1'b1);
        send(1, 7, 9, 1'b0);
        @(posedge clk);
        #1;
        chk("pt_y_active", 32'(ram_write), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ram_write", 32'(ram_write), 0);
        chk("mid_rst_ram_addr", 32'(ram_addr), 0);
        chk("mid_rst_ram_data", 32'(ram_data), 0);
        chk("mid_rst_overflow", 32'(overflow), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        exp_q.delete();
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        wlog.delete();
        send(0, 'h22, 0, 1'b1);
        chk("post_rst_w0", wlog[0], 'h000);
        chk("post_rst_w1", wlog[1], 'h122);

        // Random command mix.
        for (int i = 0; i < 400; i++) begin
            int r, t;
            r = $urandom_range(0, 99);
            t = (r < 10) ? 0 : (r < 82) ? 1 : (r < 94) ? 2 : 3;
            send(t, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
        end
        send(3, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/vector_list_writer.md
VECTOR_LIST_WRITER -- requirements
Module: vector_list_writer

Interface
REQ-001 SHALL have parameter VECTOR_RAM_WIDTH, default 9, vector RAM address width (512 bytes).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready on a clk edge.
REQ-006 SHALL have port cmd_type  input  2  0=BEGIN_LINE, 1=POINT, 2=END_LINE, 3=END_LIST.
REQ-007 SHALL have port cmd_x  input  8  BEGIN: attribute byte (colour[7:4], intensity[3:0]); POINT: x.
REQ-008 SHALL have port cmd_y  input  8  POINT: y; ignored otherwise.
REQ-009 SHALL have port ram_addr  output  VECTOR_RAM_WIDTH  vector RAM write address.
REQ-010 SHALL have port ram_data  output  8  vector RAM write data.
REQ-011 SHALL have port ram_write  output  1  write strobe, one byte per cycle.
REQ-012 SHALL have port overflow  output  1  sticky; set on any dropped point or discarded line; cleared by END_LIST.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the END_LIST terminator write.

Function
REQ-014 SHALL emit records in the renderer's format: [L][attr][x0][y0]...[x(L+1)][y(L+1)], L = points-2 (1..255), list ending in a 0 byte.
REQ-015 SHALL keep wr_ptr (next free byte) and line_start; both 0 after reset and after END_LIST.
REQ-016 States: IDLE, BEGIN_W0, BEGIN_W1, PT_X, PT_Y, PAD_X, PAD_Y, END_TERM, END_LEN, LIST_TERM, DONE.
REQ-017 cmd_ready SHALL be 1 only in IDLE; every accepted command is committed to internal registers in the accept cycle.
REQ-018 BEGIN_LINE: line_start<=wr_ptr; write 0 at line_start (provisional terminator), then attr at line_start+1; wr_ptr<=line_start+2; point count <=0.
REQ-019 POINT: write x at wr_ptr, y at wr_ptr+1 on consecutive cycles; wr_ptr+=2; count+=1.
REQ-020 POINT SHALL be dropped (no write, overflow<=1) if wr_ptr > 2^W-3, if count == 257, or if no line is open.
REQ-021 END_LINE with count >= 3: write 0 at wr_ptr (END_TERM), then count-2 at line_start (END_LEN); terminator always precedes length.
REQ-022 END_LINE with count == 2: repeat last point (PAD_X/PAD_Y), then as REQ-021 with L=1; if pad plus terminator do not fit, discard instead.
REQ-023 END_LINE with count < 2, or with no open line: discard -- write 0 at line_start, wr_ptr<=line_start, overflow<=1 if a line was open.
REQ-024 BEGIN_LINE while a line is open SHALL first apply END_LINE handling to the open line, then start the new one.
REQ-025 BEGIN_LINE SHALL be rejected (overflow<=1, no write) if wr_ptr > 2^W-3.
REQ-026 END_LIST: close any open line per END_LINE, write 0 at wr_ptr (LIST_TERM), pulse done, reset wr_ptr and line_start to 0.
REQ-027 Address arithmetic SHALL never wrap; capacity checks precede every write.
REQ-028 ram_write SHALL be 0 in IDLE and DONE; ram_addr/ram_data are don't-care while ram_write=0.

Reset
REQ-029 Reset SHALL force state IDLE, cmd_ready=1 after release, ram_write=0, ram_addr=0, ram_data=0, overflow=0, done=0, wr_ptr=0, line_start=0, count=0, line open=0.
REQ-030 Reset mid-line SHALL abandon the line; RAM contents are not repaired.

Structure
REQ-031 Shared package SHALL hold cmd_type encodings, state encodings, MAX_POINTS=257, and the record-format offsets (length 0, attr 1, first point 2).
REQ-032 No sub-module; single module.

Verification
REQ-033 BEGIN 0x3F, POINT(10,20), POINT(100,20), END_LINE, END_LIST -> writes 0:00,1:3F,2:0A,3:14,4:64,5:14,6:64,7:14,8:00,0:01,8:00; done pulses once.
REQ-034 BEGIN 0x11, POINTs (1,1),(2,2),(3,3),(4,4), END_LINE -> length byte 0x02 at line_start, terminator at line_start+10, written after it.
REQ-035 BEGIN, POINT(5,5), END_LINE -> address 0 rewritten 00, wr_ptr back to 0, overflow=1.
REQ-036 Fill to wr_ptr=510, then POINT -> no write, overflow=1; END_LIST -> 0 at last terminator location, overflow cleared.
REQ-037 258 POINTs in one line -> 258th dropped, overflow=1, END_LINE writes length 0xFF.
REQ-038 Reset asserted during PT_Y -> ram_write=0 same cycle, all outputs at reset values, next BEGIN writes at address 0.
